// File: rtl/alu_sched_pkg.sv
// ---------------------------------------------------------------------------
// alu_sched_pkg
// Shared types and defaults for the round-robin ALU scheduler.
//   state_t    : scheduler FSM states (IDLE, EXEC, RESP)
//   DEF_DATA_W : default operand width
//   DEF_OP_W   : default ALU opcode width
//   wrap_inc   : increment modulo n, valid for any n (not only powers of 2)
// ---------------------------------------------------------------------------
package alu_sched_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_OP_W   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage : alu_sched_pkg

// File: rtl/alu_rr_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first set request at or above i_ptr,
// wrapping modulo NUM_REQ. The pointer register lives in the parent.
//   i_req       : request vector
//   i_ptr       : highest-priority index
//   o_grant     : one-hot grant (all zero when no request)
//   o_grant_idx : index of the granted request
//   o_any_req   : at least one request is set
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_grant_idx,
  output logic               o_any_req
);

  always_comb begin
    int          v_pos;
    logic [ID_W-1:0] v_idx;
    // NOTE: every output gets a default before any conditional assignment,
    // so no path through the block leaves a value held (no latch).
    o_grant     = '0;
    o_grant_idx = '0;
    o_any_req   = 1'b0;
    v_pos       = 0;
    v_idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // Explicit wrap keeps the walk inside 0..NUM_REQ-1 even when NUM_REQ
      // is not a power of two.
      v_pos = int'(i_ptr) + k;
      if (v_pos >= NUM_REQ) v_pos = v_pos - NUM_REQ;
      v_idx = ID_W'(v_pos);
      if (!o_any_req && i_req[v_idx]) begin
        o_grant[v_idx] = 1'b1;
        o_grant_idx    = v_idx;
        o_any_req      = 1'b1;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/alu_rr_scheduler.sv
// ---------------------------------------------------------------------------
// alu_rr_scheduler
// Shares one combinational ALU among NUM_REQ requesters. A round-robin pick
// in IDLE latches the winner's operands, EXEC lets the ALU settle, and RESP
// presents the captured result tagged with the requester index.
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/req_ready   : per-requester handshake (ready is one-hot or 0)
//   req_a/req_b/req_op    : packed per-requester operands and opcode
//   alu_a/alu_b/alu_op    : registered operands driven to the ALU
//   alu_out/alu_cout      : combinational ALU result and carry-out
//   rsp_valid/rsp_ready   : response handshake
//   rsp_id/rsp_data/rsp_cout : owner index, captured result and carry
//   busy                  : high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module alu_rr_scheduler
  import alu_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = DEF_DATA_W,
  parameter  int OP_W    = DEF_OP_W,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic [OP_W-1:0]       alu_op,
  input  logic [2*DATA_W-1:0]   alu_out,
  input  logic                  alu_cout,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [2*DATA_W-1:0]   rsp_data,
  output logic                  rsp_cout,
  output logic                  busy
);

  state_t              r_state, w_next_state;
  logic [ID_W-1:0]     r_ptr;
  logic [DATA_W-1:0]   r_alu_a, r_alu_b;
  logic [OP_W-1:0]     r_alu_op;
  logic [ID_W-1:0]     r_rsp_id;
  logic [2*DATA_W-1:0] r_rsp_data;
  logic                r_rsp_cout;

  logic [NUM_REQ-1:0]  w_grant;
  logic [ID_W-1:0]     w_grant_idx;
  logic                w_any_req;
  logic                w_accept;

  logic [DATA_W-1:0]   w_a  [NUM_REQ];
  logic [DATA_W-1:0]   w_b  [NUM_REQ];
  logic [OP_W-1:0]     w_op [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign w_a[gi]  = req_a[gi*DATA_W +: DATA_W];
    assign w_b[gi]  = req_b[gi*DATA_W +: DATA_W];
    assign w_op[gi] = req_op[gi*OP_W +: OP_W];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req       (req_valid),
    .i_ptr       (r_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any_req   (w_any_req)
  );

  // Next state and accept. req_ready is held low while rst is high so no
  // requester believes it was accepted by an edge that resets instead.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    req_ready    = '0;
    unique case (r_state)
      IDLE: begin
        if (w_any_req && !rst) begin
          w_accept     = 1'b1;
          req_ready    = w_grant;
          w_next_state = EXEC;
        end
      end
      EXEC:    w_next_state = RESP;
      RESP:    if (rsp_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_op   <= '0;
      r_rsp_id   <= '0;
      r_rsp_data <= '0;
      r_rsp_cout <= 1'b0;
    end else begin
      r_state <= w_next_state;
      // Operands move only on an accept edge; the ALU sees them stable
      // through EXEC even if the requester changes its inputs.
      if (w_accept) begin
        r_alu_a  <= w_a[w_grant_idx];
        r_alu_b  <= w_b[w_grant_idx];
        r_alu_op <= w_op[w_grant_idx];
        r_rsp_id <= w_grant_idx;
      end
      if (r_state == EXEC) begin
        r_rsp_data <= alu_out;
        r_rsp_cout <= alu_cout;
      end
      // The served requester becomes lowest priority.
      if (r_state == RESP && rsp_ready) begin
        r_ptr <= ID_W'(wrap_inc(int'(r_rsp_id), NUM_REQ));
      end
    end
  end

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_op    = r_alu_op;
  assign rsp_valid = (r_state == RESP);
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_cout  = r_rsp_cout;
  assign busy      = (r_state != IDLE);

endmodule : alu_rr_scheduler

// File: tb/tb_alu_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_alu_rr_scheduler
// Scoreboard bench: accepts push the expected response (built from the
// driven operands and an ALU stub out = {a,b}, cout = op[0]); a negedge
// monitor pops and compares on every response handshake. Grant order is
// predicted by a distance-from-pointer reference model.
// ---------------------------------------------------------------------------
module tb_alu_rr_scheduler;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int OW = 3;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready;
  logic [N*DW-1:0] req_a, req_b;
  logic [N*OW-1:0] req_op;
  logic [DW-1:0]   alu_a, alu_b;
  logic [OW-1:0]   alu_op;
  logic [2*DW-1:0] alu_out;
  logic            alu_cout;
  logic            rsp_valid, rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [2*DW-1:0] rsp_data;
  logic            rsp_cout, busy;

  always #5 clk = ~clk;

  assign alu_out  = {alu_a, alu_b};
  assign alu_cout = alu_op[0];

  alu_rr_scheduler #(.NUM_REQ(N), .DATA_W(DW), .OP_W(OW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_cout(rsp_cout),
    .busy(busy)
  );

  typedef struct packed {
    logic [IW-1:0]   id;
    logic [2*DW-1:0] data;
    logic            cout;
  } rsp_t;

  rsp_t            sb[$];
  int              n_checks = 0;
  int              n_err    = 0;
  int              cyc      = 0;
  int              m_ptr    = 0;
  int              last_acc_cyc = -100;
  logic [N-1:0]    acc_flags = '0;
  int              acc_log[$];
  int              acc_cyc_log[$];
  logic [2*DW-1:0] rsp_log[$];
  int              rsp_id_log[$];
  logic            held = 1'b0;
  rsp_t            held_v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Winner = pending requester with the smallest forward distance from ptr.
  function automatic int ref_pick(input logic [N-1:0] v, input int p);
    int best   = -1;
    int best_d = N;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        int d;
        d = (i - p + N) % N;
        if (d < best_d) begin
          best_d = d;
          best   = i;
        end
      end
    end
    return best;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      sb.delete();
      m_ptr     = 0;
      acc_flags = '0;
      held      = 1'b0;
    end else begin
      check("ready_legal",
            32'((((req_ready & ~req_valid) == '0) && ($countones(req_ready) <= 1))), 1);
      acc_flags = req_valid & req_ready;
      if (acc_flags != '0) begin
        int   w, g;
        rsp_t e;
        w = ref_pick(req_valid, m_ptr);
        check("grant", 32'(acc_flags), (w < 0) ? 32'd0 : (32'd1 << w));
        g = 0;
        for (int i = N - 1; i >= 0; i--) if (acc_flags[i]) g = i;
        e.id   = IW'(g);
        e.data = {req_a[g*DW +: DW], req_b[g*DW +: DW]};
        e.cout = req_op[g*OW];
        sb.push_back(e);
        acc_log.push_back(g);
        acc_cyc_log.push_back(cyc);
        last_acc_cyc = cyc;
        check("accept_in_idle", 32'(busy), 0);
      end
      if (rsp_valid) begin
        if (!held) check("latency", 32'(cyc - last_acc_cyc), 2);
        else begin
          check("hold_id",   32'(rsp_id),   32'(held_v.id));
          check("hold_data", 32'(rsp_data), 32'(held_v.data));
          check("hold_cout", 32'(rsp_cout), 32'(held_v.cout));
        end
        if (rsp_ready) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_rsp: got id=%0d data=0x%0h expected no response", rsp_id, rsp_data);
          end else begin
            rsp_t e;
            e = sb.pop_front();
            check("rsp_id",   32'(rsp_id),   32'(e.id));
            check("rsp_data", 32'(rsp_data), 32'(e.data));
            check("rsp_cout", 32'(rsp_cout), 32'(e.cout));
            m_ptr = (int'(e.id) + 1) % N;
          end
          rsp_log.push_back(rsp_data);
          rsp_id_log.push_back(int'(rsp_id));
          held = 1'b0;
        end else begin
          held      = 1'b1;
          held_v.id   = rsp_id;
          held_v.data = rsp_data;
          held_v.cout = rsp_cout;
        end
      end else begin
        if (held) check("rsp_dropped", 32'(rsp_valid), 1);
        held = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_accepted();
    req_valid = req_valid & ~acc_flags;
  endtask

  task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [OW-1:0] op);
    req_a[i*DW +: DW]  = a;
    req_b[i*DW +: DW]  = b;
    req_op[i*OW +: OW] = op;
    req_valid[i]       = 1'b1;
  endtask

  task automatic clear_logs();
    acc_log.delete();
    acc_cyc_log.delete();
    rsp_log.delete();
    rsp_id_log.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_alu"}, 32'({alu_a, alu_b, alu_op}), 0);
    check({tag, "_rsp"}, 32'({rsp_valid, rsp_id, rsp_data, rsp_cout}), 0);
    check({tag, "_ctl"}, 32'({busy, req_ready}), 0);
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst = 1'b1;
    tick();
    check_zero("reset");
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(input int bound);
    int k = 0;
    while ((req_valid != '0 || busy || sb.size() != 0) && k < bound) begin
      tick();
      clear_accepted();
      k++;
    end
    n_checks++;
    if (k >= bound) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d cycles expected under %0d", k, bound);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int bc;
    int k;
    rst       = 1'b1;
    rsp_ready = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    do_reset();

    // Single request with a 2-cycle latency and busy over EXEC+RESP.
    clear_logs();
    set_req(0, 8'h18, 8'h08, 3'b001);
    #1;
    check("s1_ready", 32'(req_ready), 32'b0001);
    bc = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      clear_accepted();
      if (i == 1) check("s1_rsp", 32'({rsp_valid, rsp_id, rsp_data, rsp_cout}),
                        32'({1'b1, 2'd0, 16'h1808, 1'b1}));
      bc += int'(busy);
    end
    check("s1_busy_cycles", 32'(bc), 2);
    check("s1_rsp_count", 32'(rsp_log.size()), 1);

    // All four at once from reset: order 0..3, three cycles apart.
    do_reset();
    clear_logs();
    for (int i = 0; i < N; i++) set_req(i, DW'(i), DW'(8'h10 + i), OW'(i));
    drain(60);
    check("s2_count", 32'(acc_log.size()), 4);
    for (int i = 0; i < 4 && i < acc_log.size(); i++) check("s2_order", 32'(acc_log[i]), 32'(i));
    for (int i = 0; i < 3 && i + 1 < acc_cyc_log.size(); i++)
      check("s2_spacing", 32'(acc_cyc_log[i+1] - acc_cyc_log[i]), 3);
    for (int i = 0; i < 4 && i < rsp_log.size(); i++)
      check("s2_data", 32'(rsp_log[i]), 32'({8'(i), 8'(8'h10 + i)}));

    // Wrap: after serving 2, requests 0 and 3 go 3 then 0.
    clear_logs();
    set_req(2, 8'h02, 8'h20, 3'b000);
    drain(30);
    set_req(0, 8'h00, 8'h30, 3'b001);
    set_req(3, 8'h03, 8'h33, 3'b010);
    drain(30);
    check("s3_count", 32'(acc_log.size()), 3);
    if (acc_log.size() == 3) begin
      check("s3_first", 32'(acc_log[1]), 3);
      check("s3_second", 32'(acc_log[2]), 0);
    end

    // Backpressure: hold rsp_ready low five cycles in RESP.
    clear_logs();
    rsp_ready = 1'b0;
    set_req(1, 8'hA5, 8'h5A, 3'b110);
    set_req(2, 8'h3C, 8'hC3, 3'b011);
    k = 0;
    while (!rsp_valid && k < 10) begin
      tick();
      clear_accepted();
      k++;
    end
    check("s4_reached_resp", 32'(rsp_valid), 1);
    for (int i = 0; i < 5; i++) begin
      check("s4_valid",   32'(rsp_valid), 1);
      check("s4_noready", 32'(req_ready), 0);
      check("s4_data",    32'(rsp_data),  32'h0000A55A);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("s4_idle", 32'(busy), 0);
    check("s4_next_grant", 32'(req_ready), 32'b0100);
    drain(30);
    check("s4_ids", 32'(rsp_id_log.size() == 2 && rsp_id_log[0] == 1 && rsp_id_log[1] == 2), 1);

    // Reset during EXEC aborts; pointer returns to 0.
    clear_logs();
    set_req(0, 8'h55, 8'h01, 3'b001);
    tick();
    clear_accepted();
    check("s5_in_exec", 32'(busy), 1);
    rst = 1'b1;
    req_valid = '0;
    tick();
    check_zero("s5");
    rst = 1'b0;
    set_req(0, 8'h66, 8'h02, 3'b000);
    set_req(3, 8'h77, 8'h03, 3'b001);
    drain(30);
    check("s5_rsp_count", 32'(rsp_log.size()), 2);
    if (rsp_log.size() == 2) begin
      check("s5_first",  32'(rsp_log[0]), 32'h6602);
      check("s5_second", 32'(rsp_log[1]), 32'h7703);
    end

    // Operand hold: requester changes its inputs after the accept edge.
    clear_logs();
    set_req(0, 8'h21, 8'h43, 3'b010);
    tick();
    clear_accepted();
    req_a[0 +: DW] = 8'hFF;
    req_b[0 +: DW] = 8'hEE;
    check("s6_alu_a_exec", 32'(alu_a), 32'h21);
    tick();
    check("s6_alu_a_resp", 32'(alu_a), 32'h21);
    drain(30);
    check("s6_data", 32'(rsp_log.size() == 1 ? rsp_log[0] : 16'h0), 32'h2143);

    // Randomized traffic, random backpressure and occasional withdrawals.
    for (int c = 0; c < 400; c++) begin
      tick();
      clear_accepted();
      rsp_ready = ($urandom % 4) != 0;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && ($urandom % 3) == 0)
          set_req(i, 8'($urandom), 8'($urandom), 3'($urandom));
        else if (req_valid[i] && ($urandom % 16) == 0)
          req_valid[i] = 1'b0;
      end
    end
    rsp_ready = 1'b1;
    drain(100);
    check("end_sb_empty", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule : tb_alu_rr_scheduler
